// File: rtl/count_logger_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_logger_pkg : shared widths and FIFO entry layout           |
// | Rev 1.0 -- timestamp field under COUNT_LOGGER_TIMESTAMP_EN       |
// +------------------------------------------------------------------+
package count_logger_pkg;

  localparam int CNT_W = 4;
  localparam int TS_W  = 8;

  typedef struct packed {
`ifdef COUNT_LOGGER_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
    logic [CNT_W-1:0] cnt;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/count_logger_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : register-based FIFO, head presented combinationally  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/count_logger.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_logger : logs q on each rising edge of g into a FIFO       |
// | Rev 1.0 -- optional out_ts via COUNT_LOGGER_TIMESTAMP_EN         |
// +------------------------------------------------------------------+
module count_logger
  import count_logger_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       q,
  input  logic                   g,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow
`ifdef COUNT_LOGGER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]        out_ts
`endif
);

`ifdef COUNT_LOGGER_TIMESTAMP_EN
  localparam int ENTRY_W = TS_W + WIDTH;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic               g_q;
  logic               overflow_q;
  logic               capture;
  logic               pop;
  logic               empty;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // g_q resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) g_q <= 1'b1;
    else     g_q <= g;
  end

  assign capture = g & ~g_q;
  assign pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst)                          overflow_q <= 1'b0;
    else if (capture & full & ~pop)   overflow_q <= 1'b1;
  end

`ifdef COUNT_LOGGER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign wdata    = {ts_q, q};
  assign out_ts   = rdata[ENTRY_W-1:WIDTH];
`else
  assign wdata    = q;
`endif

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_data  = rdata[WIDTH-1:0];
  assign out_valid = ~empty;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_count_logger.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_count_logger : directed self-checking bench for count_logger  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_count_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q;
  logic       g;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       full;
  logic       overflow;
`ifdef COUNT_LOGGER_TIMESTAMP_EN
  logic [7:0] out_ts;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  count_logger #(.DEPTH(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q),
    .g         (g),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
`ifdef COUNT_LOGGER_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  // Advance one clock; inputs change and outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [3:0] v);
    g = 1'b1; q = v; step();
    g = 1'b0;        step();
  endtask

  initial begin
    rst = 1'b1; g = 1'b0; q = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);

    // First capture, 1-cycle latency
    rst = 1'b0; step();
    g = 1'b1; q = 4'd15; step();
    chk("cap1_valid", out_valid, 1);
    chk("cap1_data", out_data, 15);
    chk("cap1_level", level, 1);

    // g held high produces a single entry
    repeat (9) step();
    chk("hold_level", level, 1);
    g = 1'b0; step();
    out_ready = 1'b1; step();
    chk("pop_level", level, 0);
    chk("pop_valid", out_valid, 0);
    out_ready = 1'b0;

    // Fill, then overflow on a fifth capture
    capture(4'd3); capture(4'd7); capture(4'd11); capture(4'd15);
    chk("fill_level", level, 4);
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 0);
    capture(4'd2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 4);
    chk("ovf_head", out_data, 3);
    out_ready = 1'b1;
    chk("drain0", out_data, 3);  step();
    chk("drain1", out_data, 7);  step();
    chk("drain2", out_data, 11); step();
    chk("drain3", out_data, 15); step();
    chk("drain_level", level, 0);
    chk("drain_valid", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b0;

    // Simultaneous push and pop while full
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("rst2_ovf", overflow, 0);
    capture(4'd1); capture(4'd2); capture(4'd3); capture(4'd4);
    g = 1'b1; q = 4'd9; out_ready = 1'b1; step();
    chk("pp_level", level, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", out_data, 2);
    g = 1'b0;
    chk("pp_d0", out_data, 2); step();
    chk("pp_d1", out_data, 3); step();
    chk("pp_d2", out_data, 4); step();
    chk("pp_d3", out_data, 9); step();
    chk("pp_empty", level, 0);

    // Push with out_ready while empty, then hold without ready
    g = 1'b1; q = 4'd6; step();
    chk("ep_level", level, 1);
    chk("ep_data", out_data, 6);
    out_ready = 1'b0; g = 1'b0; step(); step();
    chk("stable_data", out_data, 6);
    chk("stable_level", level, 1);

    // g held high across reset release
    rst = 1'b1; g = 1'b1; step(); step();
    rst = 1'b0; step(); step();
    chk("hi_rel_valid", out_valid, 0);
    chk("hi_rel_level", level, 0);

    // Reset mid-operation, with a capture in the reset cycle
    g = 1'b0; step();
    capture(4'd5); capture(4'd6); capture(4'd7);
    chk("mid_level3", level, 3);
    rst = 1'b1; g = 1'b1; q = 4'd8; step();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    rst = 1'b0; g = 1'b0; step();
    chk("post_rst_level", level, 0);

`ifdef COUNT_LOGGER_TIMESTAMP_EN
    rst = 1'b1; step();
    rst = 1'b0;
    while (cyc != 5) step();
    g = 1'b1; q = 4'd1; step();
    chk("ts5", out_ts, 5);
    g = 1'b0; out_ready = 1'b1; step();
    out_ready = 1'b0;
    while (cyc != 260) step();
    g = 1'b1; q = 4'd2; step();
    chk("ts_wrap", out_ts, 4);
    chk("ts_wrap_data", out_data, 2);
    g = 1'b0; step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
